// File: rtl/biu_pkg.sv
// Shared encodings for the bus interface unit: request selects, FSM states, error fill data.
package biu_pkg;

  localparam logic [1:0] SEL_FETCH = 2'b11;
  localparam logic [1:0] SEL_RD    = 2'b01;
  localparam logic [1:0] SEL_WR    = 2'b10;
  localparam logic [1:0] SEL_ILL   = 2'b00;

  localparam logic [15:0] BUS_ERR_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDone  = 2'd2
  } biu_state_e;

endpackage

// File: rtl/biu_timeout_ctr.sv
// Strobe watchdog: counts cycles while enabled, flags the last permitted cycle.
module biu_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [7:0] cnt_q, cnt_d;

  // Clear has priority; count up while enabled and hold at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The cycle with count TIMEOUT-1 is the last one a strobe may be held.
  assign expire_o = en_i && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/biu_mem_ctrl.sv
// Bus interface unit: one request at a time, strobe/ack memory cycle, read data returned on bus.
module biu_mem_ctrl
  import biu_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs_biu,
  input  logic [1:0]    sel_biu,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ready_biu,
  output logic [DW-1:0] bus,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  biu_state_e    state_q, state_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic          is_wr_q, is_wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] bus_q, bus_d;

  logic cs_req;
  logic expire;

  // Only a solid 1 is a request; a floating or unknown strobe is ignored.
  assign cs_req = (cs_biu === 1'b1);

  biu_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk_i    (clk),
    .rst_i    (reset),
    .clr_i    (state_q != StIssue),
    .en_i     (state_q == StIssue),
    .expire_o (expire)
  );

  // Next-state and next-output logic; all outputs are registered.
  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    err_d    = 1'b0;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    bus_d    = bus_q;

    case (state_q)
      StIdle: begin
        ready_d = 1'b1;
        if (cs_req) begin
          if (sel_biu == SEL_ILL) begin
            state_d = StDone;
            err_d   = 1'b1;
          end else begin
            state_d  = StIssue;
            ready_d  = 1'b0;
            addr_d   = addr;
            wdata_d  = wdata;
            is_wr_d  = (sel_biu == SEL_WR);
            mem_rd_d = (sel_biu != SEL_WR);
            mem_wr_d = (sel_biu == SEL_WR);
          end
        end
      end

      StIssue: begin
        // Ack on the expiry cycle still completes normally.
        if (mem_ack) begin
          state_d  = StDone;
          ready_d  = 1'b1;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (!is_wr_q) begin
            bus_d = mem_rdata;
          end
        end else if (expire) begin
          state_d  = StDone;
          ready_d  = 1'b1;
          err_d    = 1'b1;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          // Only an aborted read poisons bus; an aborted write leaves it alone.
          if (!is_wr_q) begin
            bus_d = DW'(BUS_ERR_DATA);
          end
        end
      end

      StDone: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end

      default: begin
        state_d  = StIdle;
        ready_d  = 1'b1;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  // Single state/output register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      is_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      bus_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      bus_q    <= bus_d;
    end
  end

  assign ready_biu = ready_q;
  assign err       = err_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign bus       = bus_q;

endmodule
